led_matrix_scan: RTL

- Consumer end of the 256-bit frame interface produced by the pattern/animation controllers.
- Drives a 16x16 LED dot matrix by time-multiplexed row scanning, with one-hot active-low row select and active-high column data.
- Snapshots the frame into a shadow buffer once per scan frame, so a frame is never torn mid-scan.
- Inserts a blanking gap between rows to suppress ghosting.

---
 rtl/led_matrix_scan_if.sv | 28 ++
 rtl/led_matrix_scan.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_if.sv
// ----------------------------------------------------------------------------
// led_matrix_scan_if
// Frame/scan bundle between a frame producer and the LED matrix scanner.
// The master supplies the frame and enable; the slave drives the matrix.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface led_matrix_scan_if;
  logic         en;
  logic [255:0] pattern;
  logic [15:0]  row_n;
  logic [15:0]  col;
  logic [3:0]   cur_row;
  logic         frame_start;

  modport master (
    output en, pattern,
    input  row_n, col, cur_row, frame_start
  );

  modport slave (
    input  en, pattern,
    output row_n, col, cur_row, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/led_matrix_scan.sv
// ----------------------------------------------------------------------------
// led_matrix_scan
// Time-multiplexed 16x16 LED matrix row scanner. One-hot active-low row
// select, active-high columns, a dark gap before every row, and a shadow
// copy of the frame taken once per scan frame so a frame is never torn.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_matrix_scan #(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic              clk,
  input  logic              reset,
  led_matrix_scan_if.slave  bus
);

  // One counter serves both the dark gap and the row dwell.
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         cur_row_q, cur_row_d;
  logic [255:0]       buf_q, buf_d;
  logic [15:0]        row_n_q, row_n_d;
  logic [15:0]        col_q, col_d;
  logic               frame_start_q, frame_start_d;

  logic               blank_done;
  logic               dwell_done;
  logic [7:0]         row_base;

  assign blank_done = (cnt_q == CNT_W'(BLANK - 1));
  assign dwell_done = (cnt_q == CNT_W'(DWELL - 1));
  assign row_base   = {cur_row_q, 4'b0000};

  // Next-state and next-output logic; en low overrides every transition.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_row_d     = cur_row_q;
    buf_d         = buf_q;
    row_n_d       = row_n_q;
    col_d         = col_q;
    frame_start_d = 1'b0;

    if (!bus.en) begin
      // Buffer contents are deliberately kept; a restart snapshots anyway.
      state_d   = S_IDLE;
      cnt_d     = '0;
      cur_row_d = 4'd0;
      row_n_d   = 16'hFFFF;
      col_d     = 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d       = S_BLANK;
          buf_d         = bus.pattern;
          cur_row_d     = 4'd0;
          cnt_d         = '0;
          frame_start_d = 1'b1;
          row_n_d       = 16'hFFFF;
          col_d         = 16'h0000;
        end

        S_BLANK: begin
          row_n_d = 16'hFFFF;
          col_d   = 16'h0000;
          if (blank_done) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
            row_n_d = ~(16'h0001 << cur_row_q);
            col_d   = buf_q[row_base +: 16];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DRIVE: begin
          if (dwell_done) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            row_n_d = 16'hFFFF;
            col_d   = 16'h0000;
            if (cur_row_q == 4'd15) begin
              // Frame boundary: take the next snapshot while dark.
              cur_row_d     = 4'd0;
              buf_d         = bus.pattern;
              frame_start_d = 1'b1;
            end else begin
              cur_row_d = cur_row_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          cur_row_d = 4'd0;
          row_n_d   = 16'hFFFF;
          col_d     = 16'h0000;
        end
      endcase
    end
  end

  // State and output registers; reset darkens the matrix immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cur_row_q     <= 4'd0;
      buf_q         <= '0;
      row_n_q       <= 16'hFFFF;
      col_q         <= 16'h0000;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_row_q     <= cur_row_d;
      buf_q         <= buf_d;
      row_n_q       <= row_n_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.row_n       = row_n_q;
  assign bus.col         = col_q;
  assign bus.cur_row     = cur_row_q;
  assign bus.frame_start = frame_start_q;

endmodule

`default_nettype wire
